// File: rtl/axi_pkg.sv
// Shared AXI constants, size encodings and bridge state/request types for the
// cache-side SRAM-to-AXI bridges.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [7:0] LEN_SINGLE  = 8'd0;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } bridge_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // The cache never issues an 8-byte access; size 3 folds onto a word.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'd3) ? SIZE_WORD : s;
    endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe from access size and the low address bits.
module axi_wstrb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/d_cache_axi_bridge.sv
// Data-cache SRAM-like port to single-beat AXI master, one transaction in
// flight; reads are line fills, writes are dirty write-backs.
module d_cache_axi_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0] RID_VAL = 4'd1,
    parameter logic [3:0] WID_VAL = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic        axi_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    bridge_state_e state, state_nxt;
    mem_req_t      cur;
    logic          aw_done, w_done;

    // Single-beat, fixed-ID transactions: response IDs and RLAST carry no information.
    logic unused_ok;
    assign unused_ok = ^{rid, rlast, bid, cur.wr};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cur     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req)
                cur <= '{wr: wr, size: norm_size(size), addr: addr, wdata: wdata};
            if (state == ST_WR_REQ && state_nxt == ST_WR_REQ) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        axi_err   = 1'b0;
        rdata     = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state)
            ST_IDLE: begin
                addr_ok = req;
                if (req) state_nxt = wr ? ST_WR_REQ : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_ok   = 1'b1;
                    rdata     = rdata_axi;
                    axi_err   = |(rresp & RESP_SLVERR);
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; either may finish first.
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok   = 1'b1;
                    axi_err   = |(bresp & RESP_SLVERR);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign arid    = RID_VAL;
    assign araddr  = cur.addr;
    assign arlen   = LEN_SINGLE;
    assign arsize  = {1'b0, cur.size};
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = WID_VAL;
    assign awaddr  = cur.addr;
    assign awlen   = LEN_SINGLE;
    assign awsize  = {1'b0, cur.size};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid       = WID_VAL;
    assign wdata_axi = cur.wdata;
    assign wlast     = wvalid;

    axi_wstrb_gen u_wstrb (
        .size    (cur.size),
        .addr_lo (cur.addr[1:0]),
        .wstrb   (wstrb)
    );

endmodule

// File: tb/tb_d_cache_axi_bridge.sv
// Directed bench: configurable-latency AXI slave, expectation queues filled at
// issue time and drained by an independent monitor.
module tb_d_cache_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok, axi_err;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
    logic [3:0]  rid, bid;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp, bresp;
    logic        rlast, rvalid, rready, bvalid, bready;

    always #5 clk = ~clk;

    d_cache_axi_bridge dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .axi_err(axi_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // ---------------- slave model ----------------
    int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
    int          ar_wait, aw_wait, w_wait, r_wait, b_wait;
    logic        r_pend, b_pend, aw_got, w_got, aw_now, w_now;
    logic [31:0] r_data_val = '0;
    logic [1:0]  r_resp_val = '0, b_resp_val = '0;

    assign arready   = arvalid && (ar_wait >= ar_delay);
    assign awready   = awvalid && (aw_wait >= aw_delay);
    assign wready    = wvalid && (w_wait >= w_delay);
    assign rvalid    = r_pend && (r_wait >= r_delay);
    assign bvalid    = b_pend && (b_wait >= b_delay);
    assign rdata_axi = r_data_val;
    assign rresp     = r_resp_val;
    assign bresp     = b_resp_val;
    assign rlast     = 1'b1;
    assign rid       = 4'd1;
    assign bid       = 4'd1;
    assign aw_now    = aw_got || (awvalid && awready);
    assign w_now     = w_got || (wvalid && wready);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_wait <= 0; aw_wait <= 0; w_wait <= 0; r_wait <= 0; b_wait <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            r_wait  <= (r_pend && !rvalid) ? r_wait + 1 : 0;
            b_wait  <= (b_pend && !bvalid) ? b_wait + 1 : 0;
            if (arvalid && arready) r_pend <= 1'b1;
            else if (rvalid && rready) r_pend <= 1'b0;
            if (bvalid && bready) b_pend <= 1'b0;
            if (aw_now && w_now) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                aw_got <= aw_now; w_got <= w_now;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int aw_hi_cnt = 0, w_hi_cnt = 0;
    logic [34:0] exp_ar[$], exp_aw[$];   // {size, addr}
    logic [35:0] exp_w[$];               // {strb, data}
    logic [33:0] exp_done[$];            // {err, is_read, rdata}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rd(input logic [31:0] a, input logic [2:0] s3, input logic [31:0] d,
                             input logic err);
        exp_ar.push_back({s3, a});
        exp_done.push_back({err, 1'b1, d});
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [2:0] s3, input logic [31:0] d,
                             input logic [3:0] strb, input logic err);
        exp_aw.push_back({s3, a});
        exp_w.push_back({strb, d});
        exp_done.push_back({err, 1'b0, 32'h0});
    endtask

    initial begin : monitor
        logic        ar_pend, aw_pend, w_pend;
        logic [31:0] ar_prev, aw_prev;
        logic [35:0] w_prev;
        logic [34:0] ea;
        logic [35:0] ew;
        logic [33:0] ed;
        ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
        ar_prev = '0; aw_prev = '0; w_prev = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
            end else begin
                if (awvalid) aw_hi_cnt++;
                if (wvalid)  w_hi_cnt++;
                if (ar_pend) check("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
                if (aw_pend) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
                if (w_pend)  check("w_hold", {wvalid, wstrb, wdata_axi}, {1'b1, w_prev});
                if (arvalid || awvalid || wvalid)
                    check("ar_aw_overlap", arvalid && (awvalid || wvalid), 0);
                if (rready || bready) check("rb_ready_excl", rready && bready, 0);
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
                    else begin
                        ea = exp_ar.pop_front();
                        check("ar_addr_size", {arsize, araddr}, ea);
                        check("ar_consts", {arid, arlen, arburst, arlock, arcache, arprot},
                              {4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
                    end
                end
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                    else begin
                        ea = exp_aw.pop_front();
                        check("aw_addr_size", {awsize, awaddr}, ea);
                        check("aw_consts", {awid, awlen, awburst, awlock, awcache, awprot},
                              {4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        ew = exp_w.pop_front();
                        check("w_strb_data", {wstrb, wdata_axi}, ew);
                        check("w_id_last", {wid, wlast}, {4'd1, 1'b1});
                    end
                end
                if (data_ok) begin
                    check("dok_no_addr_ok", addr_ok, 0);
                    if (exp_done.size() == 0) check("data_ok_unexpected", 1, 0);
                    else begin
                        ed = exp_done.pop_front();
                        check("done_err", axi_err, ed[33]);
                        if (ed[32]) check("rd_data", rdata, ed[31:0]);
                    end
                end
                ar_pend = arvalid && !arready; ar_prev = araddr;
                aw_pend = awvalid && !awready; aw_prev = awaddr;
                w_pend  = wvalid && !wready;   w_prev  = {wstrb, wdata_axi};
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output int acc);
        logic seen;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        seen = 1'b0; acc = -1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (addr_ok) begin seen = 1'b1; acc = cyc; end
        end
        check("addr_ok_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int dc);
        logic seen;
        seen = 1'b0; dc = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (data_ok) begin seen = 1'b1; dc = cyc; end
        end
        check("data_ok_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int ac, dc, ac2, dc2, a0, w0, c0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok, axi_err}, 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("idle_outputs", {arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok, axi_err}, 0);
        @(posedge clk); #1;

        // word read, zero wait
        r_data_val = 32'hDEADBEEF;
        expect_rd(32'h1FC0_0010, 3'd2, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'd2, 32'h1FC0_0010, 32'h0, ac); req = 1'b0;
        wait_done(dc);
        check("rd_latency", dc - ac, 2);

        // byte write to lane 3
        expect_wr(32'h8000_0003, 3'd0, 32'h0000_00AB, 4'b1000, 1'b0);
        issue(1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, ac); req = 1'b0;
        wait_done(dc);
        check("wr_latency", dc - ac, 2);

        // write skew: AWREADY 3 cycles late, WREADY immediate
        aw_delay = 3; a0 = aw_hi_cnt; w0 = w_hi_cnt;
        expect_wr(32'h8000_0010, 3'd1, 32'h1234_5678, 4'b0011, 1'b0);
        issue(1'b1, 2'd1, 32'h8000_0010, 32'h1234_5678, ac); req = 1'b0;
        wait_done(dc);
        check("skew_awvalid_cycles", aw_hi_cnt - a0, 4);
        check("skew_wvalid_cycles", w_hi_cnt - w0, 1);
        check("skew_latency", dc - ac, 5);
        aw_delay = 0;

        // size 3 folds to word; upper halfword strobe
        expect_wr(32'h8000_0022, 3'd2, 32'hCAFE_F00D, 4'b1111, 1'b0);
        issue(1'b1, 2'd3, 32'h8000_0022, 32'hCAFE_F00D, ac); req = 1'b0;
        wait_done(dc);
        expect_wr(32'h8000_0006, 3'd1, 32'h5A5A_0000, 4'b1100, 1'b0);
        issue(1'b1, 2'd1, 32'h8000_0006, 32'h5A5A_0000, ac); req = 1'b0;
        wait_done(dc);

        // slow read: ARREADY 2 late, RVALID 3 late
        ar_delay = 2; r_delay = 3; r_data_val = 32'h0000_BEEF;
        expect_rd(32'h1FC0_0002, 3'd1, 32'h0000_BEEF, 1'b0);
        issue(1'b0, 2'd1, 32'h1FC0_0002, 32'h0, ac); req = 1'b0;
        wait_done(dc);
        check("slow_rd_latency", dc - ac, 7);
        ar_delay = 0; r_delay = 0;

        // back-to-back write-back then fill, req held high
        r_data_val = 32'h5566_7788;
        expect_wr(32'h8000_0100, 3'd2, 32'h1122_3344, 4'b1111, 1'b0);
        expect_rd(32'h8000_0100, 3'd2, 32'h5566_7788, 1'b0);
        issue(1'b1, 2'd2, 32'h8000_0100, 32'h1122_3344, ac);
        wr = 1'b0;
        wait_done(dc);
        issue(1'b0, 2'd2, 32'h8000_0100, 32'h0, ac2); req = 1'b0;
        check("b2b_addr_ok_gap", ac2 - dc, 1);
        wait_done(dc2);
        check("b2b_rd_latency", dc2 - ac2, 2);

        // error responses
        r_resp_val = 2'b10; r_data_val = 32'h0BAD_F00D;
        expect_rd(32'h1FC0_0020, 3'd2, 32'h0BAD_F00D, 1'b1);
        issue(1'b0, 2'd2, 32'h1FC0_0020, 32'h0, ac); req = 1'b0;
        wait_done(dc);
        @(negedge clk);
        check("err_pulse_only", {data_ok, axi_err}, 0);
        @(posedge clk); #1;
        r_resp_val = 2'b00; b_resp_val = 2'b11;
        c0 = cyc;
        expect_wr(32'h8000_0200, 3'd2, 32'hFFFF_0000, 4'b1111, 1'b1);
        issue(1'b1, 2'd2, 32'h8000_0200, 32'hFFFF_0000, ac); req = 1'b0;
        check("idle_after_err", ac - c0, 0);
        wait_done(dc);
        b_resp_val = 2'b00;

        // reset while ARVALID waits on ARREADY
        ar_delay = 100;
        issue(1'b0, 2'd2, 32'h1FC0_0080, 32'h0, ac); req = 1'b0;
        @(negedge clk);
        check("ar_stalled", {arvalid, arready}, 2'b10);
        #2 resetn = 1'b0;
        #1 check("async_abort", {arvalid, rready, addr_ok}, 0);
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
        ar_delay = 0;
        @(negedge clk);
        check("post_rst_idle", {arvalid, awvalid, wvalid, rready, bready, data_ok}, 0);
        @(posedge clk); #1;
        r_data_val = 32'h600D_CAFE;
        c0 = cyc;
        expect_rd(32'h1FC0_0084, 3'd2, 32'h600D_CAFE, 1'b0);
        issue(1'b0, 2'd2, 32'h1FC0_0084, 32'h0, ac); req = 1'b0;
        check("post_rst_accept", ac - c0, 0);
        wait_done(dc);
        check("post_rst_latency", dc - ac, 2);

        repeat (3) @(posedge clk);
        check("queues_drained", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
